// File: rtl/sort_loader_if.sv
// Bundle between sort_loader, its upstream word source and the sorter init/start port.
// master: the environment side (upstream source plus sorter); slave: the loader.
interface sort_loader_if #(
    parameter int unsigned N = 8,
    parameter int unsigned L = 4
);
    // Upstream valid/ready word stream
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_last;

    // Sorter RAM init port and run control
    logic         WrInit;
    logic [L-1:0] RAddr;
    logic [N-1:0] DataIn;
    logic         start;
    logic         done;

    modport master (
        output in_valid, in_data, in_last, done,
        input  in_ready, WrInit, RAddr, DataIn, start
    );

    modport slave (
        input  in_valid, in_data, in_last, done,
        output in_ready, WrInit, RAddr, DataIn, start
    );
endinterface

// File: rtl/sort_loader.sv
// Upstream feeder for sorting_top: collects one batch of up to DEPTH words, writes them
// into the sorter RAM, pads the remaining slots, runs the sorter and reports completion.
module sort_loader #(
    parameter int unsigned  N          = 8,
    parameter int unsigned  L          = 4,
    parameter int unsigned  DEPTH      = 8,
    parameter logic [N-1:0] PAD_VALUE  = '1,
    parameter int unsigned  TMO_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    sort_loader_if.slave     bus,
    output logic             busy,
    output logic             batch_done,
    output logic [L:0]       batch_count,
    output logic             tmo_err
);

    localparam logic [2:0] StLoad   = 3'd0;
    localparam logic [2:0] StPad    = 3'd1;
    localparam logic [2:0] StSettle = 3'd2;
    localparam logic [2:0] StRun    = 3'd3;
    localparam logic [2:0] StDrain  = 3'd4;

    localparam int unsigned TW        = (TMO_CYCLES > 0) ? $clog2(TMO_CYCLES + 1) : 1;
    localparam bit          TMO_EN    = (TMO_CYCLES != 0);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TMO_CYCLES);
    localparam logic [L:0]  LAST_IDX  = (L + 1)'(DEPTH - 1);
    localparam logic [L:0]  DEPTH_IDX = (L + 1)'(DEPTH);

    logic [2:0]    state_q, state_d;
    logic [L:0]    wr_idx_q, wr_idx_d;
    logic [L:0]    count_next_q, count_next_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          wr_init_q, wr_init_d;
    logic [L-1:0]  raddr_q, raddr_d;
    logic [N-1:0]  data_q, data_d;
    logic          start_q, start_d;
    logic          batch_done_q, batch_done_d;
    logic [L:0]    batch_count_q, batch_count_d;
    logic          tmo_err_q, tmo_err_d;

    logic          in_ready;
    logic          accept;
    logic [L:0]    wr_idx_inc;
    logic          close;

    // Ready is purely a state decode; forced low while reset is held.
    assign in_ready   = (state_q == StLoad) && !rst;
    assign accept     = bus.in_valid && in_ready;
    assign wr_idx_inc = wr_idx_q + 1'b1;
    // The DEPTH-th word closes the batch whether or not it carries in_last.
    assign close      = bus.in_last || (wr_idx_q == LAST_IDX);

    // Next-state and registered-output computation for the load/pad/run sequence
    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        count_next_d  = count_next_q;
        tmo_cnt_d     = tmo_cnt_q;
        wr_init_d     = 1'b0;
        raddr_d       = raddr_q;
        data_d        = data_q;
        start_d       = start_q;
        batch_done_d  = 1'b0;
        batch_count_d = batch_count_q;
        tmo_err_d     = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    wr_init_d = 1'b1;
                    raddr_d   = wr_idx_q[L-1:0];
                    data_d    = bus.in_data;
                    wr_idx_d  = wr_idx_inc;
                    if (close) begin
                        count_next_d = wr_idx_inc;
                        state_d      = (wr_idx_inc < DEPTH_IDX) ? StPad : StSettle;
                    end
                end
            end
            StPad: begin
                wr_init_d = 1'b1;
                raddr_d   = wr_idx_q[L-1:0];
                data_d    = PAD_VALUE;
                wr_idx_d  = wr_idx_inc;
                if (wr_idx_q == LAST_IDX) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // Final write is on the bus this cycle; the sorter commits it at this edge.
                raddr_d   = '0;
                data_d    = '0;
                start_d   = 1'b1;
                tmo_cnt_d = '0;
                state_d   = StRun;
            end
            StRun: begin
                if (bus.done) begin
                    start_d       = 1'b0;
                    batch_done_d  = 1'b1;
                    batch_count_d = count_next_q;
                    state_d       = StDrain;
                end else if (TMO_EN && (tmo_cnt_q == TMO_LIMIT)) begin
                    start_d   = 1'b0;
                    tmo_err_d = 1'b1;
                    state_d   = StDrain;
                end else if (TMO_EN) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StDrain: begin
                // Hold off the next batch until the sorter lets go of done.
                if (!bus.done) begin
                    wr_idx_d = '0;
                    state_d  = StLoad;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StLoad;
            wr_idx_q      <= '0;
            count_next_q  <= '0;
            tmo_cnt_q     <= '0;
            wr_init_q     <= 1'b0;
            raddr_q       <= '0;
            data_q        <= '0;
            start_q       <= 1'b0;
            batch_done_q  <= 1'b0;
            batch_count_q <= '0;
            tmo_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            count_next_q  <= count_next_d;
            tmo_cnt_q     <= tmo_cnt_d;
            wr_init_q     <= wr_init_d;
            raddr_q       <= raddr_d;
            data_q        <= data_d;
            start_q       <= start_d;
            batch_done_q  <= batch_done_d;
            batch_count_q <= batch_count_d;
            tmo_err_q     <= tmo_err_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.WrInit   = wr_init_q;
    assign bus.RAddr    = raddr_q;
    assign bus.DataIn   = data_q;
    assign bus.start    = start_q;

    assign busy        = !((state_q == StLoad) && (wr_idx_q == '0));
    assign batch_done  = batch_done_q;
    assign batch_count = batch_count_q;
    assign tmo_err     = tmo_err_q;

    // Completion and timeout are alternative exits from RUN.
    pulse_exclusive_a: assert property (@(posedge clk) disable iff (rst)
        !(batch_done_q && tmo_err_q));

    // The sorter never sees a RAM write while it is running.
    no_write_in_run_a: assert property (@(posedge clk) disable iff (rst)
        !(start_q && wr_init_q));

endmodule

// File: tb/tb_sort_loader.sv
// Directed bench for sort_loader: a behavioural sorter drives done, a batch-level model
// predicts the write stream, batch counts and the sorted RAM image.
module tb_sort_loader;

    localparam int unsigned N     = 8;
    localparam int unsigned L     = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 16;
    localparam logic [7:0]  PAD   = 8'hFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         busy;
    logic         batch_done;
    logic [L:0]   batch_count;
    logic         tmo_err;

    sort_loader_if #(.N(N), .L(L)) bus ();

    sort_loader #(
        .N          (N),
        .L          (L),
        .DEPTH      (DEPTH),
        .PAD_VALUE  (PAD),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .batch_done  (batch_done),
        .batch_count (batch_count),
        .tmo_err     (tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_done = 0;
    int         n_tmo = 0;
    wr_t        exp_wr [$];
    logic [L:0] exp_cnt [$];
    logic [63:0] exp_img [$];
    wr_t        cmp_e;
    logic [7:0] mem [16];
    int         done_hold = 1;
    bit         srt_never = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no/unexpected event, required the specified behaviour", name);
    endtask

    function automatic logic [63:0] mem_img();
        logic [63:0] v;
        for (int i = 0; i < DEPTH; i++) v[63 - 8*i -: 8] = mem[i];
        return v;
    endfunction

    // Sorted RAM image: real words, then PAD fill, all in ascending order.
    function automatic logic [63:0] model_img(input logic [7:0] w [$]);
        logic [7:0]  q [$];
        logic [63:0] v;
        q = w;
        while (q.size() < DEPTH) q.push_back(PAD);
        q.sort();
        for (int i = 0; i < DEPTH; i++) v[63 - 8*i -: 8] = q[i];
        return v;
    endfunction

    task automatic sort_mem();
        logic [7:0] t;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH - 1 - i; j++) begin
                if (mem[j] > mem[j+1]) begin
                    t        = mem[j];
                    mem[j]   = mem[j+1];
                    mem[j+1] = t;
                end
            end
        end
    endtask

    // Behavioural sorter: commits RAM writes at the edge, answers start after 3 cycles.
    initial begin
        int cnt = 0;
        int hold = 0;
        bit fired = 1'b0;
        bus.done = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.WrInit) mem[bus.RAddr] = bus.DataIn;
            #2;
            if (rst) begin
                bus.done = 1'b0;
                cnt = 0;
                hold = 0;
                fired = 1'b0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) bus.done = 1'b0;
            end else if (bus.start && !fired && !srt_never) begin
                cnt++;
                if (cnt == 3) begin
                    sort_mem();
                    bus.done = 1'b1;
                    hold = done_hold;
                    fired = 1'b1;
                end
            end
            if (!bus.start) begin
                cnt = 0;
                fired = 1'b0;
            end
        end
    end

    // Every-cycle compare against the batch-level model
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.WrInit) begin
                if (exp_wr.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    cmp_e = exp_wr.pop_front();
                    check("wr_addr", 64'(bus.RAddr), 64'(cmp_e.a));
                    check("wr_data", 64'(bus.DataIn), 64'(cmp_e.d));
                end
            end
            if (batch_done) begin
                n_done++;
                if (exp_cnt.size() == 0) begin
                    fail("unexpected_batch_done");
                end else begin
                    check("batch_count", 64'(batch_count), 64'(exp_cnt.pop_front()));
                    check("readback", mem_img(), exp_img.pop_front());
                end
            end
            if (tmo_err) n_tmo++;
            if (batch_done || tmo_err) check("pulse_exclusive", 64'(batch_done & tmo_err), 0);
        end
    end

    task automatic send_batch(input logic [7:0] w [$], input bit gap, input bit expect_done);
        int tmo;
        for (int i = 0; i < w.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            bus.in_last  = (i == w.size() - 1);
            tmo = 0;
            while (!bus.in_ready && tmo < 200) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo >= 200) fail("accept_wait");
            exp_wr.push_back('{a: 4'(i), d: w[i]});
            @(negedge clk);
            if (gap) begin
                check("wrinit_on_accept", 64'(bus.WrInit), 1);
                if (i < w.size() - 1) begin
                    bus.in_valid = 1'b0;
                    check("in_ready_in_load", 64'(bus.in_ready), 1);
                    @(negedge clk);
                    check("wrinit_on_stall", 64'(bus.WrInit), 0);
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = w.size(); i < DEPTH; i++) exp_wr.push_back('{a: 4'(i), d: PAD});
        if (expect_done) begin
            exp_cnt.push_back((L + 1)'(w.size()));
            exp_img.push_back(model_img(w));
        end
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!batch_done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) fail(name);
    endtask

    task automatic wait_start(input string name);
        int k = 0;
        while (!bus.start && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) fail(name);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_wrinit"}, 64'(bus.WrInit), 0);
        check({name, "_raddr"}, 64'(bus.RAddr), 0);
        check({name, "_datain"}, 64'(bus.DataIn), 0);
        check({name, "_start"}, 64'(bus.start), 0);
        check({name, "_busy"}, 64'(busy), 0);
        check({name, "_batch_done"}, 64'(batch_done), 0);
        check({name, "_batch_count"}, 64'(batch_count), 0);
        check({name, "_tmo_err"}, 64'(tmo_err), 0);
        check({name, "_in_ready"}, 64'(bus.in_ready), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] w [$];
        int k;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 64'(bus.in_ready), 1);

        // Full back-to-back batch
        w = {8'd45, 8'd12, 8'd78, 8'd34, 8'd56, 8'd89, 8'd23, 8'd67};
        send_batch(w, 1'b0, 1'b1);
        check("t1_start_in_settle", 64'(bus.start), 0);
        check("t1_in_ready_settle", 64'(bus.in_ready), 0);
        check("t1_busy", 64'(busy), 1);
        @(negedge clk);
        check("t1_start_rise", 64'(bus.start), 1);
        wait_done("t1_done_wait");
        check("t1_count_lit", 64'(batch_count), 8);
        check("t1_readback_lit", mem_img(), 64'h0C17222D38434E59);
        @(negedge clk);
        check("t1_pulse_width", 64'(batch_done), 0);

        // Short batch padded with PAD
        w = {8'd9, 8'd3, 8'd7};
        send_batch(w, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("t2_start_before", 64'(bus.start), 0);
        @(negedge clk);
        check("t2_start_rise", 64'(bus.start), 1);
        wait_done("t2_done_wait");
        check("t2_count_lit", 64'(batch_count), 3);
        check("t2_readback_lit", mem_img(), 64'h030709FFFFFFFFFF);

        // Stalled upstream
        w = {8'd200, 8'd1, 8'd150, 8'd50, 8'd100, 8'd0, 8'd250, 8'd75};
        send_batch(w, 1'b1, 1'b1);
        wait_done("t3_done_wait");
        check("t3_readback_lit", mem_img(), 64'h0001324B6496C8FA);

        // Stale done held while the next batch is offered
        done_hold = 4;
        w = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        send_batch(w, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd200;
        wait_done("t4a_done_wait");
        check("t4a_readback_lit", mem_img(), 64'h0102030405060708);
        done_hold = 1;
        k = 0;
        while (bus.done && k < 20) begin
            check("t4_in_ready_while_done", 64'(bus.in_ready), 0);
            @(negedge clk);
            k++;
        end
        if (k >= 20) fail("t4_done_release");
        check("t4_in_ready_drain", 64'(bus.in_ready), 0);
        w = {8'd200, 8'd100};
        send_batch(w, 1'b0, 1'b1);
        wait_done("t4b_done_wait");
        check("t4b_count_lit", 64'(batch_count), 2);
        check("t4b_readback_lit", mem_img(), 64'h64C8FFFFFFFFFFFF);

        // Timeout with a sorter that never answers
        srt_never = 1'b1;
        w = {8'd42};
        send_batch(w, 1'b0, 1'b0);
        wait_start("t5_start_wait");
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk);
            if (j == 16) begin
                check("t5_start_held", 64'(bus.start), 1);
                check("t5_tmo_early", 64'(tmo_err), 0);
            end else if (j == 17) begin
                check("t5_tmo_pulse", 64'(tmo_err), 1);
                check("t5_start_drop", 64'(bus.start), 0);
                check("t5_count_kept", 64'(batch_count), 2);
                check("t5_no_batch_done", 64'(batch_done), 0);
            end else if (j == 18) begin
                check("t5_tmo_width", 64'(tmo_err), 0);
                check("t5_back_idle", 64'(busy), 0);
                check("t5_in_ready", 64'(bus.in_ready), 1);
            end
        end

        // Reset three cycles into RUN
        w = {8'd5, 8'd6};
        send_batch(w, 1'b0, 1'b0);
        wait_start("t6_start_wait");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("t6");
        rst = 1'b0;
        srt_never = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_no_start", 64'(bus.start), 0);
        check("t6_idle", 64'(busy), 0);

        check("exp_wr_drained", 64'(exp_wr.size()), 0);
        check("exp_cnt_drained", 64'(exp_cnt.size()), 0);
        check("batch_done_total", 64'(n_done), 5);
        check("tmo_total", 64'(n_tmo), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
